// File: rtl/sram_wem_pkg.sv
// Shared types and helpers for the byte-masked two-port RAM (sram_wem_2p).
package sram_wem_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_t;

  localparam int unsigned RD_LAT_MAX = 2;
  localparam int unsigned PAR_DW_MAX = 1024;

  // Even parity per byte lane; lanes at or above nb are returned as 0.
  function automatic logic [PAR_DW_MAX/8-1:0] byte_par(input logic [PAR_DW_MAX-1:0] data,
                                                       input int unsigned nb);
    logic [PAR_DW_MAX/8-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < PAR_DW_MAX/8; i++) begin
      if (i < nb) p[i] = ^data[8*i +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/sram_wem_clr_fsm.sv
// Clear engine for sram_wem_2p: walks every address once, writing zero.
module sram_wem_clr_fsm
  import sram_wem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  clr_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  boot_q, boot_d;

  // State, counter and one-shot boot request; boot is re-armed by every reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
      boot_q  <= (INIT_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      boot_q  <= boot_d;
    end
  end

  // Next state: start on request or boot, run until the last address is written.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    boot_d    = 1'b0;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = cnt_q;
    unique case (state_q)
      CLR_IDLE: begin
        if (init_req || boot_q) begin
          state_d = CLR_RUN;
          cnt_d   = '0;
        end
      end
      CLR_RUN: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

endmodule

// File: rtl/sram_wem_2p.sv
// Two-port byte-masked RAM with write-first bypass, 1/2-cycle read latency
// and a clear engine. Optional per-byte parity via macro SRAM_WEM_PARITY_EN.
module sram_wem_2p
  import sram_wem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 11,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned RD_LAT        = 1,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_wem,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_din,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_dout,
  output logic                    rd_valid,
  input  logic                    init_req,
  output logic                    init_busy
`ifdef SRAM_WEM_PARITY_EN
  ,
  output logic                    par_err
`endif
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  if (RD_LAT != 1 && RD_LAT != RD_LAT_MAX) begin : g_bad_lat
    $error("sram_wem_2p: RD_LAT must be 1 or 2");
  end

  logic                  busy, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  sram_wem_clr_fsm #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .INIT_ON_RESET(INIT_ON_RESET)
  ) u_clr (
    .clk      (clk),
    .rst      (rst),
    .init_req (init_req),
    .init_busy(busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign init_busy = busy;

  logic                  mem_we;
  logic [NB-1:0]         mem_wem;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Clear engine owns the write port while busy; user write is dropped.
  always_comb begin
    mem_we    = wr_en;
    mem_wem   = wr_wem;
    mem_waddr = wr_addr;
    mem_wdata = wr_din;
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_wem   = '1;
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  logic                  rd_act, byp_hit;
  logic [NB-1:0]         byp_lane;
  logic [DATA_WIDTH-1:0] raw_word, rd_word;

  assign rd_act  = rd_en & ~busy;
  assign byp_hit = wr_en & ~busy & (wr_addr == rd_addr);

`ifdef SRAM_WEM_PARITY_EN
  logic [NB-1:0] mem_wpar, raw_par, calc_par;
  logic          rd_perr;
  assign mem_wpar = NB'(byte_par(PAR_DW_MAX'(mem_wdata), NB));
  assign calc_par = NB'(byte_par(PAR_DW_MAX'(raw_word), NB));
  // Bypassed lanes carry fresh write data, so their stored parity is irrelevant.
  assign rd_perr  = |((raw_par ^ calc_par) & ~byp_lane);
`endif

  for (genvar b = 0; b < NB; b++) begin : g_lane
    logic [7:0] lane_mem_q [DEPTH];

    // Byte lane storage, written when its mask bit is set.
    always_ff @(posedge clk) begin
      if (mem_we && mem_wem[b]) lane_mem_q[mem_waddr] <= mem_wdata[8*b +: 8];
    end

    assign raw_word[8*b +: 8] = lane_mem_q[rd_addr];
    assign byp_lane[b]        = byp_hit & wr_wem[b];
    assign rd_word[8*b +: 8]  = byp_lane[b] ? wr_din[8*b +: 8] : raw_word[8*b +: 8];

`ifdef SRAM_WEM_PARITY_EN
    logic lane_par_q [DEPTH];

    // Parity bit travels with its byte.
    always_ff @(posedge clk) begin
      if (mem_we && mem_wem[b]) lane_par_q[mem_waddr] <= mem_wpar[b];
    end

    assign raw_par[b] = lane_par_q[rd_addr];
`endif
  end

  logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
  logic                  valid1_q, valid1_d;

  // Stage-1 next value: zero data whenever no read is accepted.
  always_comb begin
    valid1_d = rd_act;
    dout1_d  = '0;
    if (rd_act) dout1_d = rd_word;
  end

  // Stage-1 read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1_q  <= '0;
      valid1_q <= 1'b0;
    end else begin
      dout1_q  <= dout1_d;
      valid1_q <= valid1_d;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dout2_q;
    logic                  valid2_q;

    // Extra output register stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        dout2_q  <= dout1_q;
        valid2_q <= valid1_q;
      end
    end

    assign rd_dout  = dout2_q;
    assign rd_valid = valid2_q;
  end else begin : g_lat1
    assign rd_dout  = dout1_q;
    assign rd_valid = valid1_q;
  end

`ifdef SRAM_WEM_PARITY_EN
  logic perr1_q;

  // Parity error flag aligned with stage-1 valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perr1_q <= 1'b0;
    else     perr1_q <= rd_act & rd_perr;
  end

  if (RD_LAT == 2) begin : g_perr2
    logic perr2_q;

    // Parity flag follows data through the extra stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) perr2_q <= 1'b0;
      else     perr2_q <= perr1_q;
    end

    assign par_err = perr2_q;
  end else begin : g_perr1
    assign par_err = perr1_q;
  end
`endif

endmodule

// File: tb/tb_sram_wem_2p.sv
// Bench for sram_wem_2p: RD_LAT=1 and RD_LAT=2 instances driven in lockstep.
module tb_sram_wem_2p;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0, rst = 1'b0;
  logic          wr_en = 1'b0, rd_en = 1'b0, init_req = 1'b0;
  logic [NB-1:0] wr_wem = '0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [DW-1:0] wr_din = '0;
  logic [DW-1:0] rd_dout1, rd_dout2;
  logic          rd_valid1, rd_valid2, busy1, busy2;
`ifdef SRAM_WEM_PARITY_EN
  logic          par_err1, par_err2;
`endif

  always #5 clk = ~clk;

  sram_wem_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1), .INIT_ON_RESET(1)) u_lat1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_wem(wr_wem), .wr_addr(wr_addr), .wr_din(wr_din),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout1), .rd_valid(rd_valid1),
    .init_req(init_req), .init_busy(busy1)
`ifdef SRAM_WEM_PARITY_EN
    , .par_err(par_err1)
`endif
  );

  sram_wem_2p #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(2), .INIT_ON_RESET(1)) u_lat2 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_wem(wr_wem), .wr_addr(wr_addr), .wr_din(wr_din),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout2), .rd_valid(rd_valid2),
    .init_req(init_req), .init_busy(busy2)
`ifdef SRAM_WEM_PARITY_EN
    , .par_err(par_err2)
`endif
  );

  // Behavioural reference: plain word array, clear countdown, expected results per latency.
  logic [DW-1:0] mem_m [DEPTH];
  int            clr_left;
  bit            boot_m;
  logic [DW-1:0] e1_d, e2_d;
  bit            e1_v, e2_v;
`ifdef SRAM_WEM_PARITY_EN
  logic [NB-1:0] bad_m [DEPTH];
  bit            e1_p, e2_p;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit            busy;
    logic [DW-1:0] rd;
`ifdef SRAM_WEM_PARITY_EN
    logic [NB-1:0] bad;
`endif
    busy = (clr_left > 0);
    e2_d = e1_d; e2_v = e1_v;
    e1_d = '0;   e1_v = 1'b0;
`ifdef SRAM_WEM_PARITY_EN
    e2_p = e1_p; e1_p = 1'b0;
`endif
    if (!busy && rd_en) begin
      rd = mem_m[rd_addr];
`ifdef SRAM_WEM_PARITY_EN
      bad = bad_m[rd_addr];
`endif
      for (int i = 0; i < NB; i++) begin
        if (wr_en && wr_addr == rd_addr && wr_wem[i]) begin
          rd[8*i +: 8] = wr_din[8*i +: 8];
`ifdef SRAM_WEM_PARITY_EN
          bad[i] = 1'b0;
`endif
        end
      end
      e1_d = rd;
      e1_v = 1'b1;
`ifdef SRAM_WEM_PARITY_EN
      e1_p = |bad;
`endif
    end
    if (busy) begin
      mem_m[DEPTH - clr_left] = '0;
`ifdef SRAM_WEM_PARITY_EN
      bad_m[DEPTH - clr_left] = '0;
`endif
      clr_left--;
    end else begin
      if (wr_en) begin
        for (int i = 0; i < NB; i++) begin
          if (wr_wem[i]) begin
            mem_m[wr_addr][8*i +: 8] = wr_din[8*i +: 8];
`ifdef SRAM_WEM_PARITY_EN
            bad_m[wr_addr][i] = 1'b0;
`endif
          end
        end
      end
      if (init_req || boot_m) clr_left = DEPTH;
    end
    boot_m = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("lat1_dout", rd_dout1, e1_d);
    check("lat1_valid", rd_valid1, e1_v);
    check("lat2_dout", rd_dout2, e2_d);
    check("lat2_valid", rd_valid2, e2_v);
    check("busy", {busy1, busy2}, {2{clr_left > 0}});
`ifdef SRAM_WEM_PARITY_EN
    check("lat1_par", par_err1, e1_p);
    check("lat2_par", par_err2, e2_p);
`endif
  endtask

  task automatic set_idle();
    wr_en = 1'b0; wr_wem = '0; wr_addr = '0; wr_din = '0;
    rd_en = 1'b0; rd_addr = '0; init_req = 1'b0;
  endtask

  task automatic rand_inputs();
    wr_en   = 1'($urandom_range(0, 1));
    wr_wem  = NB'($urandom);
    wr_addr = AW'($urandom);
    wr_din  = $urandom;
    rd_en   = 1'($urandom_range(0, 1));
    rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    e1_d = '0; e2_d = '0; e1_v = 1'b0; e2_v = 1'b0;
    clr_left = 0;
    boot_m = 1'b1;
`ifdef SRAM_WEM_PARITY_EN
    e1_p = 1'b0; e2_p = 1'b0;
    check("rst_par", {par_err1, par_err2}, 2'b00);
`endif
    check("rst_dout", {rd_dout1, rd_dout2}, 64'h0);
    check("rst_valid_busy", {rd_valid1, rd_valid2, busy1, busy2}, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic boot_count(input string name);
    int c = 0;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      step();
      if (busy1) c++;
      else if (c > 0) break;
    end
    set_idle();
    check(name, c, DEPTH);
  endtask

  task automatic read_all_zero(input string name);
    set_idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      step();
      check(name, {rd_valid1, rd_dout1}, {1'b1, 32'h0});
    end
    set_idle();
    step();
  endtask

  typedef struct {
    bit            we;
    logic [NB-1:0] wem;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            re;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_d;
    bit            exp_v;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [DW-1:0] pd;
    bit            pv;
    for (int a = 0; a < DEPTH; a++) begin
      mem_m[a] = '0;
`ifdef SRAM_WEM_PARITY_EN
      bad_m[a] = '0;
`endif
    end
    clr_left = 0; boot_m = 1'b0;
    e1_d = '0; e2_d = '0; e1_v = 1'b0; e2_v = 1'b0;
`ifdef SRAM_WEM_PARITY_EN
    e1_p = 1'b0; e2_p = 1'b0;
`endif

    tbl[0]  = '{1'b1, 4'hF, 4'd3, 32'hA5A5A5A5, 1'b0, 4'd0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 4'h1, 4'd3, 32'h00000011, 1'b0, 4'd0, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'hA5A5A511, 1'b1};
    tbl[3]  = '{1'b1, 4'hF, 4'd7, 32'hFFFFFFFF, 1'b0, 4'd0, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 4'h6, 4'd7, 32'h12345678, 1'b1, 4'd7, 32'hFF3456FF, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd7, 32'hFF3456FF, 1'b1};
    tbl[6]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0};
    tbl[9]  = '{1'b1, 4'h0, 4'd3, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 32'hA5A5A511, 1'b1};
    tbl[11] = '{1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b1, 4'd6, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 32'hDEADBEEF, 1'b1};

    #2;
    do_reset();
    boot_count("boot_busy_cycles");
    read_all_zero("boot_clear_zero");

    pd = '0; pv = 1'b0;
    for (int i = 0; i < 13; i++) begin
      wr_en = tbl[i].we; wr_wem = tbl[i].wem; wr_addr = tbl[i].wa; wr_din = tbl[i].wd;
      rd_en = tbl[i].re; rd_addr = tbl[i].ra; init_req = 1'b0;
      step();
      check("tbl_lat1", {rd_valid1, rd_dout1}, {tbl[i].exp_v, tbl[i].exp_d});
      check("tbl_lat2", {rd_valid2, rd_dout2}, {pv, pd});
      pd = tbl[i].exp_d; pv = tbl[i].exp_v;
    end
    set_idle();
    step();

`ifdef SRAM_WEM_PARITY_EN
    wr_en = 1'b1; wr_wem = 4'hF; wr_addr = 4'd9; wr_din = 32'h0F0F0F0F;
    step();
    set_idle(); rd_en = 1'b1; rd_addr = 4'd9;
    step();
    check("par_clean", {rd_valid1, par_err1}, 2'b10);
    set_idle();
    step();
    u_lat1.g_lane[0].lane_mem_q[9] = u_lat1.g_lane[0].lane_mem_q[9] ^ 8'h01;
    u_lat2.g_lane[0].lane_mem_q[9] = u_lat2.g_lane[0].lane_mem_q[9] ^ 8'h01;
    mem_m[9][0] = ~mem_m[9][0];
    bad_m[9][0] = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd9;
    step();
    check("par_flip", {rd_valid1, par_err1}, 2'b11);
    set_idle();
    step();
    check("par_flip_lat2", {rd_valid2, par_err2}, 2'b11);
`endif

    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      init_req = ($urandom_range(0, 49) == 0);
      step();
    end
    set_idle();
    for (int n = 0; n < 40 && clr_left > 0; n++) step();
    check("random_clear_done", clr_left, 0);

    // Fill with non-zero data so the clear is observable.
    for (int a = 0; a < DEPTH; a++) begin
      wr_en = 1'b1; wr_wem = '1; wr_addr = AW'(a); wr_din = $urandom | 32'h1;
      step();
    end
    set_idle(); rd_en = 1'b1; rd_addr = 4'd1;
    step();
    rd_addr = 4'd2; init_req = 1'b1;
    step();
    init_req = 1'b0; rd_addr = 4'd3;
    step();
    check("drain_lat1_nov", rd_valid1, 1'b0);
    check("drain_lat2_v", rd_valid2, 1'b1);
    rd_addr = 4'd4; wr_en = 1'b1; wr_wem = '1; wr_addr = 4'd10; wr_din = 32'hCAFEF00D;
    step();
    for (int n = 0; n < 3; n++) begin
      rand_inputs();
      init_req = 1'b1;
      step();
    end
    set_idle();
    check("clr_cnt_mid", u_lat1.u_clr.cnt_q, 5);
    do_reset();
    boot_count("reclear_busy_cycles");
    read_all_zero("reclear_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
